ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with a shared bidirectional data bus.
// Writes take one bus cycle. Reads take two bus cycles and capture the data at the end of the second.
// Every transaction finishes with a one-cycle DONE state that pulses the winner's ack.
// All outputs except ram_data come straight from flops.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  typedef enum logic [2:0] {StIdle, StWr, StRd1, StRd2, StDone} state_e;

  state_e              state_q, state_d;
  // Requester served most recently; doubles as the round-robin pointer.
  // Reset to 1 so that requester 0 wins the first tie.
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                busy_q, busy_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic                drive_q, drive_d;
  logic                win;
  logic                win_we;

  // Arbitration, next-state logic, and the next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    win     = 1'b0;
    win_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie, the requester that was not served last wins.
          if (req0 && req1) begin
            win = ~last_q;
          end else begin
            win = req1;
          end
          win_we  = win ? we1 : we0;
          last_d  = win;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          state_d = win_we ? StWr : StRd1;
        end
      end
      StWr:    state_d = StDone;
      StRd1:   state_d = StRd2;
      StRd2: begin
        state_d = StDone;
        // The RAM drives the bus during both read cycles; sample it as RD2 ends.
        rdata_d = ram_data;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so that they line up with the state they describe.
    ack0_d  = (state_d == StDone) && !last_d;
    ack1_d  = (state_d == StDone) &&  last_d;
    busy_d  = (state_d != StIdle);
    wr_en_d = (state_d == StWr);
    rd_en_d = (state_d == StRd1) || (state_d == StRd2);
    drive_d = (state_d == StWr);
  end

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      drive_q <= drive_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign ram_wr_en = wr_en_q;
  assign ram_rd_en = rd_en_q;
  assign ram_addr  = addr_q;

  // The block owns the shared bus only during WR.
  assign ram_data  = drive_q ? wdata_q : {DATA_W{1'bz}};

  // The two RAM strobes must never both be high.
  strobe_excl_a: assert property (@(posedge Clk) disable iff (!Rst_n)
    !(ram_wr_en && ram_rd_en));

  // At most one ack may be high in any cycle.
  ack_onehot_a: assert property (@(posedge Clk) disable iff (!Rst_n)
    !(ack0 && ack1));

  // An ack only appears at the end of a transaction, while busy is high.
  ack_busy_a: assert property (@(posedge Clk) disable iff (!Rst_n)
    (ack0 || ack1) |-> busy);

  // An ack lasts exactly one cycle, and the block returns to IDLE immediately afterwards.
  ack_pulse_a: assert property (@(posedge Clk) disable iff (!Rst_n)
    (ack0 || ack1) |=> !(ack0 || ack1) && !busy);

endmodule
